// File: rtl/normal_input_stage_pkg.sv
`default_nettype none
// ============================================================================
// normal_input_stage_pkg
// ----------------------------------------------------------------------------
// Shared XF definitions for the normal path front end: vertex component
// format codes, issue FSM states, packing offsets for the 96-bit x/y/z
// vectors, IEEE-754 single-precision constants and a vector packing helper.
// Revision: 1.0 - initial release
// ============================================================================
package normal_input_stage_pkg;

  // CP vertex component formats; code 3 is reserved and converts to +0.0
  typedef enum logic [1:0] {
    FMT_S8   = 2'd0,
    FMT_S16  = 2'd1,
    FMT_F32  = 2'd2,
    FMT_RSVD = 2'd3
  } comp_fmt_t;

  // Issue state of the holding register
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_TAKEN = 2'd2
  } issue_state_t;

  // Bit offsets of the components inside a 96-bit normal vector
  localparam int X_LSB = 64;
  localparam int Y_LSB = 32;
  localparam int Z_LSB = 0;

  localparam logic [7:0]  IEEE_BIAS   = 8'd127;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  // Assembly index of the final component for N-only and N/T/B vertices
  localparam logic [3:0] IDX_LAST_N   = 4'd2;
  localparam logic [3:0] IDX_LAST_NTB = 4'd8;

  function automatic logic [95:0] pack_vec(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [31:0] z);
    logic [95:0] v;
    v = '0;
    v[X_LSB +: 32] = x;
    v[Y_LSB +: 32] = y;
    v[Z_LSB +: 32] = z;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/normal_input_stage_fixed_to_float.sv
`default_nettype none
// ============================================================================
// fixed_to_float
// ----------------------------------------------------------------------------
// Purely combinational conversion of a signed 16-bit fixed-point value with
// 'frac' fractional bits into IEEE-754 single precision. Exact: a 16-bit
// magnitude always fits the 24-bit significand, so no rounding is needed.
// Ports:
//   value  in  16 : two's complement fixed-point value
//   frac   in   5 : number of fractional bits
//   result out 32 : IEEE-754 single-precision encoding (+0.0 for zero)
// Revision: 1.0 - initial release
// ============================================================================
module fixed_to_float
  import normal_input_stage_pkg::*;
(
  input  logic [15:0] value,
  input  logic [4:0]  frac,
  output logic [31:0] result
);

  logic [15:0] mag;
  logic [4:0]  lzc;
  logic [3:0]  msb;
  logic [22:0] mant;
  logic [7:0]  exp_field;

  always_comb begin
    mag = value[15] ? (~value + 16'd1) : value;

    // Leading-zero count; ascending scan so the highest set bit wins
    lzc = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (mag[i]) lzc = 5'(15 - i);
    end
    msb = 4'(5'd15 - lzc);

    // Shifting into a 23-bit field drops the hidden bit off the top
    mant      = {7'd0, mag} << (5'd23 - {1'b0, msb});
    exp_field = IEEE_BIAS + {4'd0, msb} - {3'd0, frac};

    result = (mag == 16'd0) ? FP_POS_ZERO : {value[15], exp_field, mant};
  end

endmodule
`default_nettype wire

// File: rtl/normal_input_stage.sv
`default_nettype none
// ============================================================================
// normal_input_stage
// ----------------------------------------------------------------------------
// Front end of the XF normal path. Converts incoming vertex normal
// components (s8/s16/f32) to single precision, assembles N or N/T/B
// triples and hands them to the normal transform unit via a one-deep
// holding register and a cycle/downReady handshake.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   compValid/compReady: component handshake; compData/compFormat payload
//   vtxEnableNTB       : 1 = 9-component vertex, sampled on first component
//   vtxMatrixAddr      : normal matrix index, sampled on first component
//   normalN/T/B        : issued vectors, x[95:64] y[63:32] z[31:0]
//   normalMatrixAddr, enableNTB : issued vertex attributes
//   cycle              : one-cycle issue pulse; downReady: transform free
// Revision: 1.0 - initial release
// ============================================================================
module normal_input_stage
  import normal_input_stage_pkg::*;
#(
  parameter int S8_FRAC  = 6,
  parameter int S16_FRAC = 14
)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        compValid,
  input  logic [31:0] compData,
  input  logic [1:0]  compFormat,
  output logic        compReady,
  input  logic        vtxEnableNTB,
  input  logic [4:0]  vtxMatrixAddr,
  output logic [95:0] normalN,
  output logic [95:0] normalT,
  output logic [95:0] normalB,
  output logic [4:0]  normalMatrixAddr,
  output logic        enableNTB,
  output logic        cycle,
  input  logic        downReady
);

  localparam logic [4:0] S8_FRAC_BITS  = 5'(S8_FRAC);
  localparam logic [4:0] S16_FRAC_BITS = 5'(S16_FRAC);

  // ---------------- component conversion ----------------
  logic [15:0] fix_value;
  logic [4:0]  fix_frac;
  logic [31:0] fix_result;
  logic [31:0] comp_float;

  always_comb begin
    fix_value = (compFormat == FMT_S8) ? {{8{compData[7]}}, compData[7:0]}
                                       : compData[15:0];
    fix_frac  = (compFormat == FMT_S8) ? S8_FRAC_BITS : S16_FRAC_BITS;
    case (compFormat)
      FMT_S8, FMT_S16: comp_float = fix_result;
      FMT_F32:         comp_float = compData;
      default:         comp_float = FP_POS_ZERO;
    endcase
  end

  fixed_to_float u_fixed_to_float (
    .value  (fix_value),
    .frac   (fix_frac),
    .result (fix_result)
  );

  // ---------------- assembly ----------------
  logic [8:0][31:0] asm_comp;
  logic [3:0]       idx;
  logic             asm_ntb;
  logic [4:0]       asm_addr;
  logic             asm_complete;
  logic             accept;
  logic             last;
  logic             transfer;
  issue_state_t     state, state_next;
  logic             cycle_next;

  // A full assembly register can only drain into a free holding register
  assign compReady = ~(asm_complete & (state != ST_EMPTY));
  assign accept    = compValid & compReady;
  // idx==0 is never a last index, so a stale asm_ntb there is harmless
  assign last      = asm_ntb ? (idx == IDX_LAST_NTB) : (idx == IDX_LAST_N);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      asm_comp     <= '0;
      idx          <= 4'd0;
      asm_ntb      <= 1'b0;
      asm_addr     <= 5'd0;
      asm_complete <= 1'b0;
    end else begin
      if (transfer) asm_complete <= 1'b0;
      if (accept) begin
        asm_comp[idx] <= comp_float;
        if (idx == 4'd0) begin
          asm_ntb  <= vtxEnableNTB;
          asm_addr <= vtxMatrixAddr;
        end
        if (last) begin
          idx          <= 4'd0;
          asm_complete <= 1'b1;
        end else begin
          idx <= idx + 4'd1;
        end
      end
    end
  end

  // ---------------- holding register ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      normalN          <= '0;
      normalT          <= '0;
      normalB          <= '0;
      normalMatrixAddr <= 5'd0;
      enableNTB        <= 1'b0;
    end else if (transfer) begin
      normalN          <= pack_vec(asm_comp[0], asm_comp[1], asm_comp[2]);
      normalT          <= asm_ntb ? pack_vec(asm_comp[3], asm_comp[4], asm_comp[5]) : '0;
      normalB          <= asm_ntb ? pack_vec(asm_comp[6], asm_comp[7], asm_comp[8]) : '0;
      normalMatrixAddr <= asm_addr;
      enableNTB        <= asm_ntb;
    end
  end

  // ---------------- issue FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_EMPTY;
      cycle <= 1'b0;
    end else begin
      state <= state_next;
      cycle <= cycle_next;
    end
  end

  always_comb begin
    state_next = state;
    cycle_next = 1'b0;
    transfer   = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (asm_complete) begin
          transfer   = 1'b1;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (downReady) begin
          cycle_next = 1'b1;
          state_next = ST_TAKEN;
        end
      end
      ST_TAKEN: begin
        // downReady falling means the transform unit has captured the data;
        // a waiting vertex refills the holding register in the same cycle
        if (!downReady) begin
          if (asm_complete) begin
            transfer   = 1'b1;
            state_next = ST_FULL;
          end else begin
            state_next = ST_EMPTY;
          end
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_normal_input_stage.sv
`default_nettype none
// ============================================================================
// tb_normal_input_stage
// ----------------------------------------------------------------------------
// Self-checking bench: component table with independently derived float
// encodings, vertex table, scoreboard of expected vertices and a transform
// unit model driving downReady.
// Revision: 1.0 - initial release
// ============================================================================
module tb_normal_input_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, compValid, compReady, vtxEnableNTB, enableNTB, cycle, downReady;
  logic [31:0] compData;
  logic [1:0]  compFormat;
  logic [4:0]  vtxMatrixAddr, normalMatrixAddr;
  logic [95:0] normalN, normalT, normalB;

  normal_input_stage #(.S8_FRAC(6), .S16_FRAC(14)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .compValid        (compValid),
    .compData         (compData),
    .compFormat       (compFormat),
    .compReady        (compReady),
    .vtxEnableNTB     (vtxEnableNTB),
    .vtxMatrixAddr    (vtxMatrixAddr),
    .normalN          (normalN),
    .normalT          (normalT),
    .normalB          (normalB),
    .normalMatrixAddr (normalMatrixAddr),
    .enableNTB        (enableNTB),
    .cycle            (cycle),
    .downReady        (downReady)
  );

  typedef struct { logic [1:0] fmt; logic [31:0] data; logic [31:0] exp; } comp_vec_t;
  typedef struct { int base; logic ntb; logic [4:0] addr; } vtx_vec_t;
  typedef struct { logic [95:0] n; logic [95:0] t; logic [95:0] b; logic [4:0] addr; logic ntb; } exp_vtx_t;

  comp_vec_t tbl [20];
  vtx_vec_t  vt  [6];
  exp_vtx_t  sb  [$];
  int        issue_cyc [$];
  int        checks   = 0;
  int        failures = 0;
  int        cyc      = 0;
  int        hold_lat = 2;
  logic      dr_block = 1'b0;
  logic      mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_true(input string name, input logic cond);
    checks++;
    if (cond !== 1'b1) begin
      failures++;
      $display("FAIL %s actual=0 required=1", name);
    end
  endtask

  function automatic exp_vtx_t build_exp(input vtx_vec_t v);
    exp_vtx_t e;
    e.n = {tbl[v.base].exp, tbl[v.base+1].exp, tbl[v.base+2].exp};
    e.t = '0;
    e.b = '0;
    if (v.ntb) begin
      e.t = {tbl[v.base+3].exp, tbl[v.base+4].exp, tbl[v.base+5].exp};
      e.b = {tbl[v.base+6].exp, tbl[v.base+7].exp, tbl[v.base+8].exp};
    end
    e.addr = v.addr;
    e.ntb  = v.ntb;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  // Vertex attributes are scrambled after the first component.
  task automatic send_comp(input int ti, input logic first, input logic ntb, input logic [4:0] addr);
    int waited = 0;
    compValid     = 1'b1;
    compFormat    = tbl[ti].fmt;
    compData      = tbl[ti].data;
    vtxEnableNTB  = first ? ntb : ~ntb;
    vtxMatrixAddr = first ? addr : ~addr;
    #1;
    while (!compReady && waited < 1000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!compReady) expect_true("accept_timeout", compReady);
    @(negedge clk);
    compValid = 1'b0;
  endtask

  task automatic send_vertex(input vtx_vec_t v);
    int n = v.ntb ? 9 : 3;
    sb.push_back(build_exp(v));
    for (int k = 0; k < n; k++) send_comp(v.base + k, k == 0, v.ntb, v.addr);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sb.size() != 0 || !downReady || mon_busy) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    expect_true("drain", sb.size() == 0 && downReady && !mon_busy);
    repeat (2) @(negedge clk);
  endtask

  // Transform unit model: captures on cycle, keeps downReady high for
  // hold_lat cycles, drops it for one cycle, then raises it unless blocked.
  initial begin
    exp_vtx_t    e;
    logic [95:0] cn, ct, cb;
    logic [4:0]  ca;
    int          w;
    downReady = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && cycle === 1'b1) begin
        mon_busy = 1'b1;
        issue_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_cycle actual=issue required=none");
        end else begin
          e = sb.pop_front();
          chk("normalN", normalN, e.n);
          chk("normalT", normalT, e.t);
          chk("normalB", normalB, e.b);
          chk("normalMatrixAddr", normalMatrixAddr, e.addr);
          chk("enableNTB", enableNTB, e.ntb);
        end
        cn = normalN; ct = normalT; cb = normalB; ca = normalMatrixAddr;
        for (int k = 0; k < hold_lat; k++) begin
          @(negedge clk);
          chk("cycle_width", cycle, 1'b0);
          chk("stable_N", normalN, cn);
          chk("stable_T", normalT, ct);
          chk("stable_B", normalB, cb);
          chk("stable_addr", normalMatrixAddr, ca);
        end
        downReady = 1'b0;
        @(negedge clk);
        w = 0;
        while (dr_block && w < 5000) begin
          @(negedge clk);
          w++;
        end
        if (dr_block) expect_true("block_timeout", !dr_block);
        downReady = 1'b1;
        mon_busy  = 1'b0;
      end
    end
  end

  initial begin
    exp_vtx_t hb;
    int       n0;
    resetn = 1'b0; compValid = 1'b0; compData = '0; compFormat = '0;
    vtxEnableNTB = 1'b0; vtxMatrixAddr = '0;

    tbl[0]  = '{2'd0, 32'h0000_0040, 32'h3F80_0000};
    tbl[1]  = '{2'd0, 32'h0000_00C0, 32'hBF80_0000};
    tbl[2]  = '{2'd0, 32'h0000_0000, 32'h0000_0000};
    tbl[3]  = '{2'd0, 32'h0000_007F, 32'h3FFE_0000};
    tbl[4]  = '{2'd0, 32'h0000_0080, 32'hC000_0000};
    tbl[5]  = '{2'd0, 32'h0000_0001, 32'h3C80_0000};
    tbl[6]  = '{2'd1, 32'h0000_4000, 32'h3F80_0000};
    tbl[7]  = '{2'd1, 32'h0000_0001, 32'h3880_0000};
    tbl[8]  = '{2'd2, 32'h7FC0_0001, 32'h7FC0_0001};
    tbl[9]  = '{2'd2, 32'h0000_0001, 32'h0000_0001};
    tbl[10] = '{2'd2, 32'hC2F6_0000, 32'hC2F6_0000};
    tbl[11] = '{2'd2, 32'h3F00_0000, 32'h3F00_0000};
    tbl[12] = '{2'd2, 32'h8000_0000, 32'h8000_0000};
    tbl[13] = '{2'd2, 32'h1234_5678, 32'h1234_5678};
    tbl[14] = '{2'd2, 32'hFF80_0000, 32'hFF80_0000};
    tbl[15] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[16] = '{2'd1, 32'hABCD_FFFF, 32'hB880_0000};
    tbl[17] = '{2'd0, 32'h1234_56FE, 32'hBD00_0000};
    tbl[18] = '{2'd1, 32'h0000_8000, 32'hC000_0000};
    tbl[19] = '{2'd1, 32'h0000_7FFF, 32'h3FFF_FE00};

    vt[0] = '{0,  1'b0, 5'd3};
    vt[1] = '{3,  1'b0, 5'd7};
    vt[2] = '{6,  1'b1, 5'd21};
    vt[3] = '{15, 1'b0, 5'd1};
    vt[4] = '{16, 1'b0, 5'd30};
    vt[5] = '{17, 1'b0, 5'd31};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_compReady", compReady, 1'b1);
    chk("rst_cycle", cycle, 1'b0);
    chk("rst_normalN", normalN, '0);
    chk("rst_normalT", normalT, '0);
    chk("rst_normalB", normalB, '0);
    chk("rst_addr", normalMatrixAddr, 5'd0);
    chk("rst_enableNTB", enableNTB, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // s8 N-only vertex and issue latency
    send_vertex(vt[0]);
    chk("lat_t1_cycle", cycle, 1'b0);
    @(negedge clk);
    chk("lat_t2_cycle", cycle, 1'b0);
    chk("lat_t2_normalN", normalN, 96'h3F800000_BF800000_00000000);
    @(negedge clk);
    chk("lat_t3_cycle", cycle, 1'b1);
    wait_idle();

    // Back-to-back vertices: extremes, NTB pass-through, reserved format
    for (int i = 1; i < 6; i++) send_vertex(vt[i]);
    wait_idle();

    // Backpressure: transform unit stays busy after the first vertex
    dr_block = 1'b1;
    n0 = issue_cyc.size();
    send_vertex(vt[0]);
    send_vertex(vt[1]);
    send_vertex(vt[3]);
    chk("bp_ready_low", compReady, 1'b0);
    repeat (6) @(negedge clk);
    hb = build_exp(vt[1]);
    chk("bp_ready_held", compReady, 1'b0);
    chk("bp_hold_N", normalN, hb.n);
    chk("bp_issue_count", issue_cyc.size(), n0 + 1);
    dr_block = 1'b0;
    wait_idle();
    chk("bp_issue_all", issue_cyc.size(), n0 + 3);
    if (issue_cyc.size() == n0 + 3)
      chk("bp_no_bubble", issue_cyc[n0+2] - issue_cyc[n0+1], hold_lat + 2);

    // Reset during a partial NTB vertex
    for (int k = 0; k < 5; k++) send_comp(vt[2].base + k, k == 0, 1'b1, 5'd9);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_normalN", normalN, '0);
    chk("rst2_addr", normalMatrixAddr, 5'd0);
    chk("rst2_compReady", compReady, 1'b1);
    resetn = 1'b1;
    @(negedge clk);
    send_vertex(vt[2]);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("total_issues", issue_cyc.size(), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/normal_input_stage.md
# normal_input_stage

Front end of the XF normal path. Accepts raw vertex normal components one per cycle in CP vertex formats (s8, s16, f32), converts each to IEEE-754 single precision, assembles N or N/T/B triples, and issues them to the normal transform unit through its `cycle`/`ready` handshake. A one-deep holding register lets collection of the next vertex overlap the downstream transform.

## Interface
Parameters:
- `S8_FRAC`, 6: fractional bits of s8 components (value = int·2^-6).
- `S16_FRAC`, 14: fractional bits of s16 components.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `compValid` in 1: component present on `compData`.
- `compData` in 32: s8 in [7:0], s16 in [15:0], f32 in [31:0]; unused bits ignored.
- `compFormat` in 2: 0=s8, 1=s16, 2=f32, 3=reserved (component converts to +0.0).
- `compReady` out 1: component accepted when `compValid & compReady`.
- `vtxEnableNTB` in 1: sampled with the first component of a vertex; 1 = 9 components (N,T,B), 0 = 3 (N).
- `vtxMatrixAddr` in 5: sampled with the first component; normal matrix index.
- `normalN`, `normalT`, `normalB` out 96: x in [95:64], y in [63:32], z in [31:0].
- `normalMatrixAddr` out 5, `enableNTB` out 1: vertex attributes.
- `cycle` out 1: one-cycle issue pulse to the transform unit.
- `downReady` in 1: transform unit free (high = can accept).

## Operation
- Assembly counter `idx` 0..8; component order Nx,Ny,Nz,Tx,Ty,Tz,Bx,By,Bz. At `idx==0`, `vtxEnableNTB`/`vtxMatrixAddr` are latched.
- Conversion (combinational, per component): integer v sign-extended, magnitude m; m==0 → 0x00000000; else p = MSB index of m, exponent = 127 + p − FRAC, mantissa = m shifted so bit p is the hidden bit, low bits zero-filled. Exact, no rounding. f32 passes through unchanged (including NaN/denormal). Format is per component.
- Vertex complete when last component (idx 2 or 8) accepted; `idx` returns to 0.
- Holding register: complete vertex transfers from assembly to holding on the cycle after completion if holding is free; otherwise assembly stalls (`compReady=0`) until transfer.
- Issue FSM on holding register:
  - EMPTY: holding free. On transfer → FULL.
  - FULL: when `downReady`, assert `cycle` for one cycle → TAKEN.
  - TAKEN: outputs held stable; when `downReady==0` (transform unit captured data) → EMPTY, or → FULL in the same cycle if a completed vertex is waiting.
- `normalT`/`normalB` are don't-care when `enableNTB==0`; they are driven with +0.0.
- `compReady = ~(assemblyComplete & holdingBusy)`.

## Timing
- Reset (resetn low at clk edge): `compReady`=1 after reset, `cycle`=0, all data outputs 0, `enableNTB`=0, `normalMatrixAddr`=0, `idx`=0, FSM EMPTY. Partial vertices and held vertices are discarded; no `cycle` is issued for them.
- Accepted component is registered; last accept at edge t → holding loaded at t+1 → `cycle` earliest at t+2 (registered, high for exactly one cycle).
- Outputs change only on transfer to holding, never while FULL or TAKEN.
- `compValid` with `compReady` low: component not consumed; source holds it.
- Simultaneous TAKEN→EMPTY and waiting vertex: transfer occurs that cycle, no bubble.
- `downReady` low in FULL: stay FULL indefinitely; no timeout.

## Structure
- Shared XF package: format codes (`FMT_S8/S16/F32`), component packing offsets, IEEE constants (bias 127, +0.0).
- One sub-module: `fixed_to_float` (signed 16-bit value, frac count → 32-bit float, purely combinational, leading-zero count), instantiated once on the component path.

## Test plan
- s8 N-only: components 0x40, 0xC0, 0x00 → `normalN`=0x3F800000_BF800000_00000000, `enableNTB`=0, one `cycle` pulse at accept+2.
- s8 extremes: 0x7F, 0x80, 0x01 → 0x3FFE0000, 0xC0000000, 0x3C800000.
- s16 NTB: Nx=0x4000 (→0x3F800000), Ny=0x0001 (→0x38800000), remaining seven f32 values pass through bit-exact; `enableNTB`=1, `normalMatrixAddr` matches value latched at first component.
- Backpressure: hold `downReady`=0, stream three vertices → second assembles into holding wait, `compReady` drops after third completes; release → vertices issued in order, outputs stable between `cycle` and `downReady` falling.
- Reserved format 3 with data 0xFFFFFFFF → component 0x00000000.
- Reset after 5 of 9 NTB components → no `cycle`; next vertex starts at Nx and issues correctly.
